// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the serial link transmitter and receiver.
// Codeword bit[i-1] holds position i.
package hamming_pkg;

  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int D3 = 3;
  localparam int P4 = 4;
  localparam int D5 = 5;
  localparam int D6 = 6;
  localparam int D7 = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // nibble[0]=d3 [1]=d5 [2]=d6 [3]=d7
  function automatic logic [6:0] encode74(input logic [3:0] nibble);
    logic [6:0] w;
    w         = '0;
    w[D3-1]   = nibble[0];
    w[D5-1]   = nibble[1];
    w[D6-1]   = nibble[2];
    w[D7-1]   = nibble[3];
    w[P1-1]   = nibble[0] ^ nibble[1] ^ nibble[3];
    w[P2-1]   = nibble[0] ^ nibble[2] ^ nibble[3];
    w[P4-1]   = nibble[1] ^ nibble[2] ^ nibble[3];
    return w;
  endfunction

endpackage

// File: rtl/hamming74_encode.sv
// Combinational Hamming(7,4) encoder with optional single-position fault injection.
// inject_pos 1..7 flips that codeword position; 0 leaves the word intact.
module hamming74_encode
  import hamming_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic [2:0] inject_pos,
  output logic [6:0] word
);

  logic [6:0] flip;

  always_comb begin
    flip = '0;
    if (inject_pos != 3'd0) flip = 7'd1 << (inject_pos - 3'd1);
    word = encode74(nibble) ^ flip;
  end

endmodule

// File: rtl/hamming_serial_tx.sv
// Hamming(7,4) serial transmitter: START(0), positions 1..7 LSB-first, STOP(1),
// each bit held CLKS_PER_BIT clocks.
//
//  state | meaning
//  IDLE  | line high, in_ready=1, waiting for a nibble
//  START | start bit (0) on the line
//  DATA  | codeword position bit_cnt+1 on the line
//  STOP  | stop bit (1); frame_done on its last cycle
module hamming_serial_tx
  import hamming_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] inject_pos,
  output logic       serial_out,
  output logic       busy,
  output logic       frame_done,
  output logic [6:0] codeword
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state, state_nxt;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift;
  logic [6:0]    enc_word;
  logic          xfer;
  logic          tick;

  hamming74_encode u_enc (
    .nibble     (in_data),
    .inject_pos (inject_pos),
    .word       (enc_word)
  );

  assign xfer = in_valid && in_ready;
  assign tick = (clk_cnt == CNT_LAST);

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (xfer) state_nxt = START;
      START: begin
        busy = 1'b1;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        busy = 1'b1;
        if (tick && bit_cnt == 3'd6) state_nxt = STOP;
      end
      STOP: begin
        busy       = 1'b1;
        frame_done = tick;
        if (tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      serial_out <= 1'b1;
      in_ready   <= 1'b1;
      codeword   <= 7'd0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == IDLE);

      if (state == IDLE || tick) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + CW'(1);

      // The line is driven one bit ahead: each tick loads the next period's value.
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          bit_cnt    <= 3'd0;
          if (xfer) begin
            codeword   <= enc_word;
            shift      <= enc_word;
            serial_out <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            serial_out <= shift[0];
            shift      <= shift >> 1;
            bit_cnt    <= 3'd0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd6) begin
              serial_out <= 1'b1;
            end else begin
              serial_out <= shift[0];
              shift      <= shift >> 1;
              bit_cnt    <= bit_cnt + 3'd1;
            end
          end
        end
        STOP:    serial_out <= 1'b1;
        default: serial_out <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_serial_tx.sv
// Bench for hamming_serial_tx: table-driven frames on a CLKS_PER_BIT=1 instance
// checked by a serial monitor/scoreboard, plus hand sequences on a CLKS_PER_BIT=4 instance.
module tb_hamming_serial_tx;

  typedef struct {
    logic [3:0] data;
    logic [2:0] inj;
    logic [6:0] cw;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic [3:0] in_data1 = '0;
  logic       in_valid1 = 1'b0;
  logic [2:0] inject_pos1 = '0;
  logic       in_ready1, serial_out1, busy1, frame_done1;
  logic [6:0] codeword1;

  logic [3:0] in_data4 = '0;
  logic       in_valid4 = 1'b0;
  logic [2:0] inject_pos4 = '0;
  logic       in_ready4, serial_out4, busy4, frame_done4;
  logic [6:0] codeword4;

  hamming_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .inject_pos(inject_pos1), .serial_out(serial_out1),
    .busy(busy1), .frame_done(frame_done1), .codeword(codeword1)
  );

  hamming_serial_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clock(clock), .reset(reset), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .inject_pos(inject_pos4), .serial_out(serial_out4),
    .busy(busy4), .frame_done(frame_done4), .codeword(codeword4)
  );

  always #5 clock = ~clock;

  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  int   last_xfer = 0;
  int   frames_seen = 0;
  exp_t exp_q[$];

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Serial monitor and loopback receiver for dut1 (one sample per bit).
  bit         cap = 1'b0;
  int         idx = 0;
  logic [8:0] bits;
  logic [6:0] cw_seen;
  bit         fd_ok, rb_ok, cw_ok;
  logic [6:0] r;
  logic [2:0] syn;
  exp_t       e;

  always @(negedge clock) begin
    if (reset) begin
      cap = 1'b0;
    end else if (!cap) begin
      if (serial_out1 == 1'b0) begin
        cap     = 1'b1;
        idx     = 1;
        bits    = '0;
        cw_seen = codeword1;
        fd_ok   = (frame_done1 == 1'b0);
        rb_ok   = busy1 && !in_ready1;
        cw_ok   = 1'b1;
      end
    end else begin
      bits[idx] = serial_out1;
      if (frame_done1 != (idx == 8)) fd_ok = 1'b0;
      if (!busy1 || in_ready1) rb_ok = 1'b0;
      if (codeword1 != cw_seen) cw_ok = 1'b0;
      if (idx == 8) begin
        cap = 1'b0;
        frames_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(bits), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("codeword", 32'(cw_seen), 32'(e.cw));
          chk("serial_frame", 32'(bits), 32'({1'b1, e.cw, 1'b0}));
          chk("frame_done_pos", 32'(fd_ok), 32'd1);
          chk("busy_ready_in_frame", 32'({rb_ok, cw_ok}), 32'd3);
          r = bits[7:1];
          syn = {r[3] ^ r[4] ^ r[5] ^ r[6], r[1] ^ r[2] ^ r[5] ^ r[6], r[0] ^ r[2] ^ r[4] ^ r[6]};
          if (syn != 3'd0) r[syn - 3'd1] = ~r[syn - 3'd1];
          chk("rx_syndrome", 32'(syn), 32'(e.inj));
          chk("rx_nibble", 32'({r[6], r[5], r[4], r[2]}), 32'(e.data));
        end
      end
      idx++;
    end
  end

  task automatic send1(input logic [3:0] d, input logic [2:0] inj, input logic [6:0] cw, input bit hold);
    int   g;
    exp_t x;
    g = 0;
    @(negedge clock);
    in_data1    = d;
    inject_pos1 = inj;
    in_valid1   = 1'b1;
    while (!in_ready1 && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (g >= 200) chk("send_ready_timeout", 32'd1, 32'd0);
    x.data = d;
    x.inj  = inj;
    x.cw   = cw;
    exp_q.push_back(x);
    last_xfer = edge_cnt + 1;
    @(posedge clock);
    #1;
    if (!hold) in_valid1 = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || cap) && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (g >= 100) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  exp_t vecs[8];
  int   t0;
  int   nframes;
  bit   fd_seen;
  logic [8:0] ef4;

  initial begin
    vecs[0] = '{4'b1011, 3'd0, 7'h55};
    vecs[1] = '{4'b1011, 3'd3, 7'h51};
    vecs[2] = '{4'h0,    3'd0, 7'h00};
    vecs[3] = '{4'hF,    3'd0, 7'h7F};
    vecs[4] = '{4'h5,    3'd0, 7'h2D};
    vecs[5] = '{4'hF,    3'd7, 7'h3F};
    vecs[6] = '{4'h0,    3'd1, 7'h01};
    vecs[7] = '{4'h8,    3'd0, 7'h4B};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_serial_out", 32'({serial_out1, serial_out4}), 32'd3);
    chk("rst_in_ready", 32'({in_ready1, in_ready4}), 32'd3);
    chk("rst_busy_done", 32'({busy1, busy4, frame_done1, frame_done4}), 32'd0);
    chk("rst_codeword", 32'({codeword1, codeword4}), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      send1(vecs[i].data, vecs[i].inj, vecs[i].cw, 1'b0);
      wait_idle();
    end
    nframes = 8;

    // back-to-back with in_valid held: 9 frame cycles + 1 idle between transfers
    send1(4'h0, 3'd0, 7'h00, 1'b1);
    t0 = last_xfer;
    send1(4'hF, 3'd0, 7'h7F, 1'b0);
    chk("b2b_xfer_spacing", 32'(last_xfer - t0), 32'd10);
    wait_idle();
    nframes += 2;

    // CLKS_PER_BIT=4 frame: 36 cycles, each bit held 4 cycles
    @(negedge clock);
    in_data4  = 4'h5;
    in_valid4 = 1'b1;
    chk("cpb4_ready_before", 32'(in_ready4), 32'd1);
    @(posedge clock);
    #1;
    in_valid4 = 1'b0;
    ef4 = {1'b1, 7'h2D, 1'b0};
    for (int i = 0; i < 36; i++) begin
      @(negedge clock);
      chk($sformatf("cpb4_cycle%0d", i), 32'({serial_out4, frame_done4, in_ready4, busy4}),
          32'({ef4[i / 4], (i == 35), 1'b0, 1'b1}));
    end
    chk("cpb4_codeword", 32'(codeword4), 32'h2D);
    @(negedge clock);
    chk("cpb4_after", 32'({serial_out4, in_ready4, busy4}), 32'b110);

    // reset during DATA bit 3 aborts the frame
    send1(4'h0, 3'd0, 7'h00, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("abort_state", 32'({serial_out1, in_ready1, busy1, frame_done1}), 32'b1100);
    chk("abort_codeword", 32'(codeword1), 32'h0);
    reset = 1'b0;
    exp_q.delete();
    fd_seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (frame_done1 || busy1 || !serial_out1) fd_seen = 1'b1;
    end
    chk("abort_quiet", 32'(fd_seen), 32'd0);
    send1(4'h5, 3'd0, 7'h2D, 1'b0);
    wait_idle();
    nframes += 1;

    // in_valid pulse while busy is ignored
    send1(4'h8, 3'd0, 7'h4B, 1'b0);
    repeat (3) @(negedge clock);
    in_data1    = 4'h3;
    inject_pos1 = 3'd5;
    in_valid1   = 1'b1;
    @(negedge clock);
    in_valid1 = 1'b0;
    chk("busy_ignore_codeword", 32'(codeword1), 32'h4B);
    wait_idle();
    nframes += 1;
    repeat (15) @(negedge clock);
    chk("frame_count", 32'(frames_seen), 32'(nframes));
    chk("scoreboard_empty", 32'({exp_q.size() != 0, cap}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
